rand_share_ctrl: RTL and testbench

Round-robin scheduler that shares one 32-bit Fibonacci LFSR mask generator among several masked-DES consumers (S-box masking, key-schedule masking, dummy-round insertion). It owns the LFSR state, loads and warms it up from a seed, and hands out one fresh 32-bit random word per grant. It also guarantees that no two requesters ever receive the same word, and that no word is issued before the warm-up is complete.

---
 rtl/rand_share_ctrl_pkg.sv | 24 ++
 rtl/rand_share_ctrl_rr_pick.sv | 28 ++
 rtl/rand_share_ctrl.sv | 112 +++++++++++
 tb/tb_rand_share_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rand_share_ctrl_pkg.sv
// Shared constants and types for the masked-DES random word scheduler.
package rand_share_ctrl_pkg;

    localparam int LFSR_W = 32;

    // Feedback taps, numbered with bit 1 as the MSB.
    localparam int TAP_0 = 32;
    localparam int TAP_1 = 22;
    localparam int TAP_2 = 2;
    localparam int TAP_3 = 1;

    localparam logic [1:LFSR_W] ZERO_SEED_SUB = 32'h0000_0001;

    typedef enum logic {
        WARM,
        SERVE
    } rng_state_e;

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    function automatic logic [1:LFSR_W] seed_fix(input logic [1:LFSR_W] s);
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/rand_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    winner_o,
    output logic             any_o
);

    logic [PW-1:0] idx;

    // Scan from the lowest priority down so the last hit is the highest priority.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_i) + i) % N_REQ);
            if (req_i[idx]) begin
                winner_o = idx;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rand_share_ctrl.sv
// Shares one 32-bit Fibonacci LFSR among N_REQ requesters, one unique word per grant.
// Grant one cycle after a winning request; reseed/reset re-enters a WARMUP-step warm-up.
module rand_share_ctrl
    import rand_share_ctrl_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:LFSR_W]  seed_in,
    input  logic             seed_load,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:LFSR_W]  rnd_out,
    output logic             rnd_valid,
    output logic             rng_ready
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

    rng_state_e      state_q, state_d;
    logic [1:LFSR_W] lfsr_q, lfsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [1:LFSR_W] rnd_q, rnd_d;

    logic            fb;
    logic [1:LFSR_W] lfsr_step;
    logic [PW-1:0]   winner;
    logic            any_req;

    assign fb        = lfsr_q[TAP_0] ^ lfsr_q[TAP_1] ^ lfsr_q[TAP_2] ^ lfsr_q[TAP_3];
    assign lfsr_step = {fb, lfsr_q[1:LFSR_W-1]};

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        rnd_d   = rnd_q;
        if (seed_load) begin
            state_d = WARM;
            lfsr_d  = seed_fix(seed_in);
            cnt_d   = '0;
            ptr_d   = '0;
        end else begin
            case (state_q)
                WARM: begin
                    if (WARMUP == 0) begin
                        state_d = SERVE;
                    end else begin
                        lfsr_d = lfsr_step;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == WARM_LAST) begin
                            state_d = SERVE;
                        end
                    end
                end
                SERVE: begin
                    // Free-running so issued words do not track the access pattern.
                    lfsr_d = lfsr_step;
                    if (any_req) begin
                        gnt_d = ONE << winner;
                        rnd_d = lfsr_q;
                        ptr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WARM;
            lfsr_q  <= seed_fix(seed_in);
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_out   = rnd_q;
    assign rnd_valid = |gnt_q;
    assign rng_ready = (state_q == SERVE);

endmodule

// File: tb/tb_rand_share_ctrl.sv
// Bench for rand_share_ctrl: two instances (WARMUP=0 and WARMUP=32), one active at a time.
module tb_rand_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int          cur = 0;
    logic        rst_v = 1'b0;
    logic        load_v = 1'b0;
    logic [3:0]  req_v = 4'h0;
    logic [31:0] seed_v = 32'h0;

    logic        rst_a, rst_b, load_a, load_b;
    logic [3:0]  req_a, req_b, gnt_a, gnt_b;
    logic [31:0] rnd_a, rnd_b;
    logic        val_a, val_b, rdy_a, rdy_b;

    assign rst_a  = (cur == 0) ? rst_v : 1'b0;
    assign rst_b  = (cur != 0) ? rst_v : 1'b0;
    assign load_a = (cur == 0) ? load_v : 1'b0;
    assign load_b = (cur != 0) ? load_v : 1'b0;
    assign req_a  = (cur == 0) ? req_v : 4'h0;
    assign req_b  = (cur != 0) ? req_v : 4'h0;

    rand_share_ctrl #(.N_REQ(4), .WARMUP(0)) u_dut0 (
        .clk(clk), .rst(rst_a), .seed_in(seed_v), .seed_load(load_a), .req(req_a),
        .gnt(gnt_a), .rnd_out(rnd_a), .rnd_valid(val_a), .rng_ready(rdy_a)
    );

    rand_share_ctrl #(.N_REQ(4), .WARMUP(32)) u_dut32 (
        .clk(clk), .rst(rst_b), .seed_in(seed_v), .seed_load(load_b), .req(req_b),
        .gnt(gnt_b), .rnd_out(rnd_b), .rnd_valid(val_b), .rng_ready(rdy_b)
    );

    logic [3:0]  o_gnt;
    logic [31:0] o_rnd;
    logic        o_val, o_rdy;
    assign o_gnt = (cur != 0) ? gnt_b : gnt_a;
    assign o_rnd = (cur != 0) ? rnd_b : rnd_a;
    assign o_val = (cur != 0) ? val_b : val_a;
    assign o_rdy = (cur != 0) ? rdy_b : rdy_a;

    // Reference model: cycles since the last seed event, and the word index that implies.
    int          m_n = 0;
    int          m_ptr = 0;
    logic [31:0] m_seed = 32'h1;
    logic [3:0]  e_gnt = 4'h0;
    logic [31:0] e_rnd = 32'h0;
    logic        e_rdy = 1'b0;
    int          nerr = 0;
    int          nchk = 0;

    function automatic logic [31:0] fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    // Plain LSB-indexed view: spec bit k lives at v[32-k].
    function automatic logic [31:0] adv(input logic [31:0] s, input int k);
        logic [31:0] v;
        logic f;
        v = s;
        for (int i = 0; i < k; i++) begin
            f = v[31] ^ v[30] ^ v[10] ^ v[0];
            v = {f, v[31:1]};
        end
        return v;
    endfunction

    function automatic int wval();
        return (cur != 0) ? 32 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int w;
        int j;
        int rdy_n;
        rdy_n = (wval() > 0) ? wval() : 1;
        @(posedge clk);
        if (!rst_v) begin
            m_seed = fix(seed_v); m_n = 0; m_ptr = 0; e_gnt = 4'h0; e_rnd = 32'h0;
        end else if (load_v) begin
            m_seed = fix(seed_v); m_n = 0; m_ptr = 0; e_gnt = 4'h0;
        end else begin
            m_n++;
            e_gnt = 4'h0;
            if (m_n - 1 >= rdy_n && req_v != 4'h0) begin
                w = -1;
                for (int i = 0; i < 4; i++) begin
                    j = (m_ptr + i) % 4;
                    if (w < 0 && req_v[j]) w = j;
                end
                e_gnt = 4'(1 << w);
                e_rnd = adv(m_seed, m_n - 1 - ((wval() == 0) ? 1 : 0));
                m_ptr = (w + 1) % 4;
            end
        end
        e_rdy = (m_n >= rdy_n);
        #1;
        chk("gnt", 32'(o_gnt), 32'(e_gnt));
        chk("rnd_out", o_rnd, e_rnd);
        chk("rnd_valid", 32'(o_val), 32'(|e_gnt));
        chk("rng_ready", 32'(o_rdy), 32'(e_rdy));
    endtask

    task automatic rand_run(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            load_v = ($urandom_range(0, 39) == 0);
            if (load_v) seed_v = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            req_v = req_v | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            cyc();
            load_v = 1'b0;
            req_v = req_v & ~e_gnt;
        end
    endtask

    // Waits a bounded time for the first grant after a seed event; returns cycles taken.
    task automatic wait_gnt(output int n, output logic got);
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            n++;
            if (o_gnt != 4'h0) got = 1'b1;
        end
    endtask

    logic [31:0] seq_exp [4];
    logic [3:0]  rr_exp [5];
    int          nwait;
    logic        got;

    initial begin
        seq_exp = '{32'h8000_0000, 32'hC000_0000, 32'h6000_0000, 32'hB000_0000};
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // ---- WARMUP = 0 ----
        cur = 0; rst_v = 1'b0; seed_v = 32'h8000_0000; req_v = 4'h0;
        cyc(); cyc();
        chk("reset_gnt", 32'(o_gnt), 32'h0);
        chk("reset_rnd", o_rnd, 32'h0);
        chk("reset_ready", 32'(o_rdy), 32'h0);

        rst_v = 1'b1; req_v = 4'b0001;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("seq_word", o_rnd, seq_exp[i]);
            chk("seq_gnt", 32'(o_gnt), 32'h1);
        end
        req_v = 4'h0; cyc();
        req_v = 4'b0001; cyc();
        chk("skip_word", o_rnd, 32'h6C00_0000);

        rst_v = 1'b0; seed_v = 32'h0; req_v = 4'h0; cyc();
        rst_v = 1'b1; req_v = 4'b0001; cyc();
        cyc(); chk("zero_seed_w0", o_rnd, 32'h0000_0001);
        cyc(); chk("zero_seed_w1", o_rnd, 32'h8000_0000);

        rst_v = 1'b0; seed_v = 32'hDEAD_BEEF; req_v = 4'h0; cyc();
        rst_v = 1'b1; req_v = 4'hF; cyc();
        for (int i = 0; i < 5; i++) begin
            cyc(); chk("rr_full", 32'(o_gnt), 32'(rr_exp[i]));
        end
        req_v = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc(); chk("rr_1010", 32'(o_gnt), (i % 2 == 0) ? 32'h2 : 32'h8);
        end

        req_v = 4'hF; seed_v = 32'h1234_5678; load_v = 1'b1; cyc();
        chk("reseed_no_gnt", 32'(o_gnt), 32'h0);
        chk("reseed_ready", 32'(o_rdy), 32'h0);
        load_v = 1'b0; cyc(); cyc();
        chk("reseed_ptr0", 32'(o_gnt), 32'h1);
        chk("reseed_word", o_rnd, 32'h1234_5678);
        req_v = 4'h0;

        rand_run(200);

        // ---- WARMUP = 32 ----
        cur = 1; rst_v = 1'b0; load_v = 1'b0; req_v = 4'h0; seed_v = $urandom();
        cyc();
        chk("w32_reset_rdy", 32'(o_rdy), 32'h0);
        rst_v = 1'b1; req_v = 4'hF;
        for (int i = 0; i < 31; i++) begin
            cyc();
            chk("warm_ready_low", 32'(o_rdy), 32'h0);
            chk("warm_gnt_low", 32'(o_gnt), 32'h0);
        end
        cyc(); chk("warm_ready_up", 32'(o_rdy), 32'h1);
        cyc();
        chk("warm_first_gnt", 32'(o_gnt), 32'h1);
        chk("warm_first_word", o_rnd, adv(fix(seed_v), 32));

        cyc(); cyc(); cyc();
        seed_v = $urandom(); load_v = 1'b1; cyc();
        chk("w32_reseed_gnt", 32'(o_gnt), 32'h0);
        chk("w32_reseed_rdy", 32'(o_rdy), 32'h0);
        load_v = 1'b0;
        wait_gnt(nwait, got);
        chk("w32_reseed_seen", 32'(got), 32'h1);
        chk("w32_reseed_lat", 32'(nwait), 32'd33);
        chk("w32_reseed_ptr", 32'(o_gnt), 32'h1);
        chk("w32_reseed_word", o_rnd, adv(fix(seed_v), 32));

        cyc(); cyc();
        rst_v = 1'b0; cyc();
        chk("midrst_gnt", 32'(o_gnt), 32'h0);
        chk("midrst_rnd", o_rnd, 32'h0);
        chk("midrst_val", 32'(o_val), 32'h0);
        chk("midrst_rdy", 32'(o_rdy), 32'h0);
        rst_v = 1'b1;
        wait_gnt(nwait, got);
        chk("midrst_seen", 32'(got), 32'h1);
        chk("midrst_word", o_rnd, adv(fix(seed_v), 32));
        req_v = 4'h0;

        rand_run(300);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
